rto_core_dispatch: RTL and testbench

//  Real-time output core fed by the AXI write bridge (rto_core_write/rto_core_fifo_din).

---
 rtl/rto_pkg.sv | 10 +
 rtl/rto_sync_fifo.sv | 47 ++++
 rtl/rto_core_dispatch.sv | 78 +++++++
 tb/tb_rto_core_dispatch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rto_pkg.sv
// rto_pkg: FSM state codes and timed-entry field positions for the real-time output core
package rto_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam int TS_MSB   = 127;
    localparam int TS_LSB   = 64;
    localparam int DATA_MSB = 63;
    localparam int DATA_LSB = 0;
endpackage

// File: rtl/rto_sync_fifo.sv
// rto_sync_fifo: single-clock FIFO with registered read data and synchronous flush
module rto_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             s_axi_aclk,
    input  logic             s_axi_aresetn,
    input  logic             flush,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign push  = wr_en && !full && !flush;
    assign pop   = rd_en && !empty && !flush;
    always_ff @(posedge s_axi_aclk) begin
        if (push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/rto_core_dispatch.sv
// rto_core_dispatch: buffers timed entries and releases each payload when the free-running timer reaches its timestamp
module rto_core_dispatch
    import rto_pkg::*;
#(
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int TS_WIDTH        = 64,
    parameter int DATA_WIDTH      = 64
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  rto_core_reset,
    input  logic                  rto_core_flush,
    input  logic                  rto_core_write,
    input  logic [127:0]          rto_core_fifo_din,
    input  logic                  timer_enable,
    output logic                  rto_core_full,
    output logic                  rto_core_empty,
    output logic [DATA_WIDTH-1:0] rto_dout,
    output logic                  rto_dout_valid,
    output logic [TS_WIDTH-1:0]   rto_timer,
    output logic                  late_error,
    output logic                  overflow_error
);
    logic                  core_resetn;
    logic [1:0]            state;
    logic [TS_WIDTH-1:0]   ts_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [127:0]          fifo_dout;
    logic                  rd_en, release_now;
    assign core_resetn = s_axi_aresetn && !rto_core_reset;
    assign rd_en       = state == ST_IDLE && !rto_core_empty;
    assign release_now = state == ST_WAIT && rto_timer >= ts_q;
    rto_sync_fifo #(
        .WIDTH(128),
        .DEPTH(FIFO_DEPTH),
        .AW(FIFO_ADDR_WIDTH)
    ) u_fifo (
        .s_axi_aclk   (s_axi_aclk),
        .s_axi_aresetn(core_resetn),
        .flush        (rto_core_flush),
        .wr_en        (rto_core_write),
        .rd_en        (rd_en),
        .din          (rto_core_fifo_din),
        .dout         (fifo_dout),
        .full         (rto_core_full),
        .empty        (rto_core_empty)
    );
    always_ff @(posedge s_axi_aclk) begin
        if (!core_resetn) begin
            state          <= ST_IDLE;
            rto_timer      <= '0;
            ts_q           <= '0;
            data_q         <= '0;
            rto_dout       <= '0;
            rto_dout_valid <= 1'b0;
            late_error     <= 1'b0;
            overflow_error <= 1'b0;
        end else begin
            rto_timer      <= rto_timer + TS_WIDTH'(timer_enable);
            rto_dout_valid <= release_now && !rto_core_flush;
            overflow_error <= overflow_error || (rto_core_write && rto_core_full && !rto_core_flush);
            state          <= rto_core_flush     ? ST_IDLE :
                              rd_en              ? ST_LOAD :
                              state == ST_LOAD   ? ST_WAIT :
                              release_now        ? ST_IDLE : state;
            if (state == ST_LOAD) begin
                ts_q   <= fifo_dout[TS_MSB:TS_LSB];
                data_q <= fifo_dout[DATA_MSB:DATA_LSB];
            end
            // a flush in the release cycle suppresses the payload and the late check
            if (release_now && !rto_core_flush) begin
                rto_dout   <= data_q;
                late_error <= late_error || rto_timer > ts_q;
            end
        end
    end
endmodule

// File: tb/tb_rto_core_dispatch.sv
// tb_rto_core_dispatch: directed stimulus against a cycle-level release model of the real-time output core
module tb_rto_core_dispatch;
    logic         s_axi_aclk = 1'b0;
    logic         s_axi_aresetn, rto_core_reset, rto_core_flush, rto_core_write, timer_enable;
    logic [127:0] rto_core_fifo_din;
    logic         rto_core_full, rto_core_empty, rto_dout_valid, late_error, overflow_error;
    logic [63:0]  rto_dout, rto_timer;

    rto_core_dispatch dut (
        .s_axi_aclk       (s_axi_aclk),
        .s_axi_aresetn    (s_axi_aresetn),
        .rto_core_reset   (rto_core_reset),
        .rto_core_flush   (rto_core_flush),
        .rto_core_write   (rto_core_write),
        .rto_core_fifo_din(rto_core_fifo_din),
        .timer_enable     (timer_enable),
        .rto_core_full    (rto_core_full),
        .rto_core_empty   (rto_core_empty),
        .rto_dout         (rto_dout),
        .rto_dout_valid   (rto_dout_valid),
        .rto_timer        (rto_timer),
        .late_error       (late_error),
        .overflow_error   (overflow_error)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    typedef struct {logic [63:0] ts; logic [63:0] d;} ent_t;
    typedef struct {logic [63:0] d; logic [63:0] t; logic late;} pulse_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: entries wait in a queue; the head is picked up once the core is idle,
    // becomes eligible two cycles later, and is released when the timer reaches its timestamp.
    ent_t        mq[$];
    ent_t        st;
    bit          st_v = 0;
    int          cyc = 0, elig = 0, idle_from = 0, m_sz;
    logic [63:0] m_timer = '0, m_dout = '0;
    logic        m_valid = 0, m_late = 0, m_ovf = 0;

    always @(posedge s_axi_aclk) begin
        cyc++;
        if (!s_axi_aresetn || rto_core_reset) begin
            mq.delete();
            st_v = 0; m_timer = '0; m_dout = '0; m_valid = 0; m_late = 0; m_ovf = 0;
            idle_from = cyc + 1;
        end else begin
            m_valid = 0;
            if (rto_core_flush) begin
                mq.delete();
                st_v = 0;
                idle_from = cyc + 1;
            end else begin
                m_sz = mq.size();
                if (st_v && cyc >= elig && m_timer >= st.ts) begin
                    m_dout = st.d; m_valid = 1;
                    if (m_timer > st.ts) m_late = 1;
                    st_v = 0;
                    idle_from = cyc + 1;
                end else if (!st_v && cyc >= idle_from && m_sz > 0) begin
                    st = mq.pop_front();
                    st_v = 1;
                    elig = cyc + 2;
                end
                if (rto_core_write) begin
                    if (m_sz == 16) m_ovf = 1;
                    else mq.push_back('{ts: rto_core_fifo_din[127:64], d: rto_core_fifo_din[63:0]});
                end
            end
            if (timer_enable) m_timer = m_timer + 64'd1;
        end
    end

    pulse_t plog[$];

    initial begin
        @(posedge s_axi_aclk);
        forever begin
            @(negedge s_axi_aclk);
            chk("timer", rto_timer, m_timer);
            chk("full", rto_core_full, mq.size() == 16);
            chk("empty", rto_core_empty, mq.size() == 0);
            chk("dout_valid", rto_dout_valid, m_valid);
            chk("dout", rto_dout, m_dout);
            chk("late_error", late_error, m_late);
            chk("overflow_error", overflow_error, m_ovf);
            if (rto_dout_valid === 1'b1) plog.push_back('{d: rto_dout, t: rto_timer, late: late_error});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge s_axi_aclk);
    endtask

    task automatic push(input logic [63:0] ts, input logic [63:0] d);
        rto_core_write    = 1'b1;
        rto_core_fifo_din = {ts, d};
        tick(1);
        rto_core_write    = 1'b0;
    endtask

    logic [63:0] t0, base;

    initial begin
        s_axi_aresetn = 0; rto_core_reset = 0; rto_core_flush = 0; rto_core_write = 0;
        timer_enable = 0; rto_core_fifo_din = '0;
        tick(3);
        chk("rst_empty", rto_core_empty, 1);
        chk("rst_full", rto_core_full, 0);
        chk("rst_timer", rto_timer, 0);
        chk("rst_valid", rto_dout_valid, 0);
        // 1: on-time release
        s_axi_aresetn = 1; timer_enable = 1;
        push(64'd20, 64'hA5);
        tick(30);
        chk("t1_pulses", plog.size(), 1);
        if (plog.size() > 0) begin
            chk("t1_dout", plog[0].d, 64'hA5);
            chk("t1_timer", plog[0].t, 64'd21);
        end
        chk("t1_late", late_error, 0);
        // 2: timestamp already passed
        plog.delete();
        while (m_timer < 64'd50) tick(1);
        t0 = m_timer;
        push(64'd5, 64'd1);
        tick(6);
        chk("t2_pulses", plog.size(), 1);
        if (plog.size() > 0) begin
            chk("t2_dout", plog[0].d, 64'd1);
            chk("t2_timer", plog[0].t, t0 + 64'd4);
            chk("t2_late", plog[0].late, 1);
        end
        // 3: one staged + 16 buffered, the 18th write is dropped
        plog.delete();
        timer_enable = 0;
        base = m_timer + 64'd30;
        for (int i = 0; i < 18; i++) begin
            if (i == 17) begin
                chk("t3_full", rto_core_full, 1);
                chk("t3_ovf_before", overflow_error, 0);
            end
            push(base + 64'(i), 64'h300 + 64'(i));
        end
        chk("t3_ovf", overflow_error, 1);
        timer_enable = 1;
        tick(110);
        chk("t3_pulses", plog.size(), 17);
        for (int i = 0; i < 17 && i < plog.size(); i++) chk("t3_order", plog[i].d, 64'h300 + 64'(i));
        // 4: flush while waiting
        plog.delete();
        base = m_timer + 64'd20;
        for (int i = 0; i < 4; i++) push(base + 64'(i), 64'h400 + 64'(i));
        tick(2);
        t0 = m_timer;
        rto_core_flush = 1;
        tick(1);
        rto_core_flush = 0;
        chk("t4_empty", rto_core_empty, 1);
        chk("t4_timer", rto_timer, t0 + 64'd1);
        chk("t4_ovf_kept", overflow_error, 1);
        tick(60);
        chk("t4_pulses", plog.size(), 0);
        // 5: soft reset mid-WAIT with a coincident write
        plog.delete();
        push(m_timer + 64'd100, 64'h55);
        tick(4);
        rto_core_reset = 1; rto_core_write = 1; rto_core_fifo_din = {64'd0, 64'h66};
        tick(1);
        rto_core_reset = 0; rto_core_write = 0;
        chk("t5_timer", rto_timer, 0);
        chk("t5_empty", rto_core_empty, 1);
        chk("t5_late", late_error, 0);
        chk("t5_ovf", overflow_error, 0);
        chk("t5_valid", rto_dout_valid, 0);
        tick(20);
        chk("t5_pulses", plog.size(), 0);
        // 7: write while full coincident with flush leaves overflow clear
        timer_enable = 0;
        for (int i = 0; i < 17; i++) push(64'd1000 + 64'(i), 64'h700 + 64'(i));
        chk("t7_full", rto_core_full, 1);
        rto_core_flush = 1; rto_core_write = 1; rto_core_fifo_din = {64'd0, 64'h77};
        tick(1);
        rto_core_flush = 0; rto_core_write = 0;
        chk("t7_ovf", overflow_error, 0);
        chk("t7_empty", rto_core_empty, 1);
        // 6: two entries with the same timestamp
        plog.delete();
        timer_enable = 1;
        push(64'd100, 64'h61);
        push(64'd100, 64'h62);
        for (int i = 0; i < 200 && plog.size() < 2; i++) tick(1);
        tick(2);
        chk("t6_pulses", plog.size(), 2);
        if (plog.size() > 1) begin
            chk("t6_d0", plog[0].d, 64'h61);
            chk("t6_t0", plog[0].t, 64'd101);
            chk("t6_late0", plog[0].late, 0);
            chk("t6_d1", plog[1].d, 64'h62);
            chk("t6_t1", plog[1].t, 64'd104);
            chk("t6_late1", plog[1].late, 1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
